fetch_queue: RTL
================

# fetch_queue

Decoupling buffer between the PC register / instruction memory (IF) and the decode stage (ID) of the pipelined CPU. It tracks the one-cycle in-flight synchronous imem read and captures each returned {pc, instruction} pair into a small FIFO. It presents the FIFO head to decode with a valid/ready handshake, and drives the PC register's stall input when the FIFO could overflow. A branch/jump redirect flushes all queued and in-flight fetches.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `INSTR_WIDTH`, 32: instruction and PC width.
- `clk` input, 1: rising-edge clock.
- `rstn` input, 1: reset, synchronous, active-low.
- `pc_addr` input, INSTR_WIDTH: fetch PC presented to imem this cycle (pc_register output).
- `fetch_req` input, 1: IF wants to issue a fetch at `pc_addr` this cycle.
- `imem_rdata` input, INSTR_WIDTH: imem read data; valid the cycle after the issuing cycle.
- `flush` input, 1: redirect; discard queued and in-flight fetches.
- `id_ready` input, 1: decode accepts the head entry this cycle.
- `pc_stall` output, 1: drives pc_register `stall_ctr`.
- `id_valid` output, 1: head entry valid.
- `id_pc` output, INSTR_WIDTH: PC of head entry.
- `id_instr` output, INSTR_WIDTH: instruction of head entry.
- `count` output, $clog2(DEPTH)+1: occupied entries.

## Operation
- **Issue.** A fetch is issued when `fetch_req & ~pc_stall & ~flush`. On issue, register `infl_valid<=1` and `infl_pc<=pc_addr`; otherwise `infl_valid<=0`.
- **Push.** When `infl_valid & ~flush`, {`infl_pc`, `imem_rdata`} is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- **Pop.** When `id_valid & id_ready & ~flush`, `rd_ptr` increments modulo DEPTH.
- **Head outputs.** `id_valid = (count!=0) & ~flush`. `id_pc` and `id_instr` are read combinationally from the `rd_ptr` entry.
- **Count.** `count` is +1 on push only, −1 on pop only, and unchanged on simultaneous push+pop.
- **Overflow guard.** `pc_stall = (count + infl_valid) >= DEPTH`. It depends only on registers, so there is no combinational path from `id_ready`. It is conservative and guarantees no push ever hits a full FIFO.
- **Flush.** Next cycle: `count=0`, `rd_ptr=wr_ptr=0`, `infl_valid=0`. The push and pop in the flush cycle are suppressed. The fetch at the old-path `pc_addr` in the flush cycle is not recorded.
- **Priority.** `rstn` > `flush` > push/pop.
- **Reset mid-operation.** All in-flight and queued state is discarded, the same as a flush.
- **Reset values.** `pc_stall=0`, `id_valid=0`, `count=0`, `id_pc=0`, `id_instr=0`. Storage array is cleared to 0.

## Timing
- No bypass: `fetch_req` issue at cycle t → `imem_rdata` at t+1 → push at end of t+1 → `id_valid=1` at t+2. Latency is 2 cycles.
- DEPTH=4 sustains one instruction per cycle when `id_ready` is held high. Steady state is `count≤2`, `infl_valid=1`, with `pc_stall` never asserted.
- `pc_stall` asserted at cycle t takes effect on the pc_register edge at the end of t. Issue is blocked in cycle t.
- `flush` at t: `id_valid=0` during t. `pc_stall=0` from t+1. The redirect PC from pc_register is issued at t+1.

## Configuration
- **`FETCH_QUEUE_BYPASS_EN` defined.** When `count==0 & infl_valid & ~flush`, present {`infl_pc`, `imem_rdata`} directly on the ID outputs with `id_valid=1`.
  - If `id_ready`, the entry is consumed and not written.
  - Otherwise it is pushed normally.
  - Latency drops to 1 cycle.
  - This adds a combinational path from imem to ID.
- **Undefined.** Head outputs come from storage only; latency is 2 cycles.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_WIDTH=32`
  - `NOP_INSTR=32'h0000_0000`
  - typedef `fetch_entry_t` {pc, instr}, reused by the IF/ID and ID/EX registers.
- Sub-module `fetch_queue_fifo`:
  - generic DEPTH×entry FIFO with push, pop, clear, count and head.
  - The top level holds the in-flight tracking, the stall computation and the bypass mux.

## Test plan
- **Reset.** Hold `rstn=0` 3 cycles with `fetch_req=1` → `id_valid=0`, `count=0`, `pc_stall=0`, `id_pc=0`, `id_instr=0`.
- **Streaming.** `fetch_req=1`, `id_ready=1`, PCs 0x00,0x04,0x08…, imem returns `instr=pc^0xA5A5_0000` → from cycle 2, one entry per cycle in PC order; `pc_stall` never asserts.
- **Backpressure.** As above with `id_ready=0` → `count` reaches 3 with `infl_valid=1`, `pc_stall=1`; `count` peaks at 4 with no entry lost or duplicated. Raise `id_ready` → PCs 0x00…0x0C drain in order and fetching resumes.
- **Flush.** Flush at cycle 5 with `count=2` and a fetch in flight → `id_valid=0` at cycle 5, `count=0` at cycle 6. The redirect PC 0x100 appears on `id_pc` at cycle 8 (cycle 7 with bypass). No old-path PC is ever presented.
- **Simultaneous push+pop.** At `count=1` → `count` stays 1; pointers wrap past DEPTH−1 correctly over 10 cycles.
- **Bypass.** `FETCH_QUEUE_BYPASS_EN`: empty queue, single fetch at t with `id_ready=1` → `id_valid` at t+1 and `count` stays 0. With `id_ready=0` → entry is pushed and `count=1` at t+2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and constants shared across the CPU pipeline stages.
// fetch_entry_t is the {pc, instr} pair that the IF/ID and ID/EX registers also carry.
package cpu_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic DEPTH x WIDTH circular FIFO with push, pop, synchronous clear,
// occupancy count and a combinational head read. DEPTH must be a power of 2,
// so the pointers wrap naturally. The caller never pushes when full and never
// pops when empty.
module fetch_queue_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
)
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    import cpu_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;

    // Storage, pointers and count; reset also zeroes the array, clear only rewinds.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_queue.sv
// Decoupling buffer between IF (pc register + synchronous imem) and ID.
// Tracks the single in-flight imem read, captures each returned {pc, instr}
// into a FIFO, presents the head to decode with valid/ready, and stalls the
// PC register when the FIFO could overflow. A flush discards everything.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a returning
// fetch straight to ID when the queue is empty (1-cycle latency, adds a
// combinational imem -> ID path).
module fetch_queue
#(
    parameter int DEPTH       = 4,
    parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
)
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [INSTR_WIDTH-1:0]   pc_addr,
    input  logic                     fetch_req,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     pc_stall,
    output logic                     id_valid,
    output logic [INSTR_WIDTH-1:0]   id_pc,
    output logic [INSTR_WIDTH-1:0]   id_instr,
    output logic [$clog2(DEPTH):0]   count
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * INSTR_WIDTH;

    logic                   infl_valid;
    logic [INSTR_WIDTH-1:0] infl_pc;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   q_nonempty;
    logic [EW-1:0]          wdata;
    logic [EW-1:0]          head;
    logic [CW-1:0]          q_count;
    logic [CW:0]            occupancy;

    // A fetch is only recorded when IF is not stalled and not being redirected.
    assign issue = fetch_req & ~pc_stall & ~flush;

    // In-flight imem read: the PC whose data arrives on imem_rdata next cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            infl_valid <= 1'b0;
            infl_pc    <= '0;
        end else begin
            infl_valid <= issue;
            if (issue) begin
                infl_pc <= pc_addr;
            end
        end
    end

    // Counting the in-flight read as occupied keeps the guard register-only
    // (no path from id_ready) and guarantees a push never meets a full FIFO.
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, infl_valid};
    assign pc_stall  = (occupancy >= (CW+1)'(DEPTH));

    assign q_nonempty = (q_count != '0);
    assign wdata      = {infl_pc, imem_rdata};
    assign pop        = q_nonempty & id_ready & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // An empty queue lets the returning fetch go straight to ID; if ID takes
    // it this cycle it is never written.
    assign bypass   = ~q_nonempty & infl_valid & ~flush;
    assign push     = infl_valid & ~flush & ~(bypass & id_ready);
    assign id_valid = (q_nonempty | bypass) & ~flush;
    assign id_pc    = bypass ? infl_pc    : head[EW-1 -: INSTR_WIDTH];
    assign id_instr = bypass ? imem_rdata : head[INSTR_WIDTH-1:0];
`else
    assign push     = infl_valid & ~flush;
    assign id_valid = q_nonempty & ~flush;
    assign id_pc    = head[EW-1 -: INSTR_WIDTH];
    assign id_instr = head[INSTR_WIDTH-1:0];
`endif

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (q_count)
    );

    assign count = q_count;

endmodule
